// File: rtl/calc_sequencer.sv
// Two-requester instruction sequencer for the calculator.
// Round-robin loads instructions, then drives timed execute runs.
module calc_sequencer #(
  parameter int DEPTH = 32,
  parameter int RUN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [6:0]       a_instr,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [6:0]       b_instr,
  output logic             b_ready,
  input  logic             run_start,
  input  logic [RUN_W-1:0] run_len,
  input  logic             flush,
  output logic             calc_mode,
  output logic [2:0]       calc_opCode,
  output logic [3:0]       calc_value,
  output logic             calc_en,
  output logic             calc_clr,
  output logic [5:0]       load_count,
  output logic             full,
  output logic             busy,
  output logic             rejected,
  output logic             done
);

  typedef enum logic {LOAD, EXEC} state_e;

  state_e           state_q, state_d;
  logic [RUN_W-1:0] cnt_q, cnt_d;
  logic             ptr_b_q;
  logic             fwd_q;
  logic             open_c;
  logic             grant_a;
  logic             grant_b;
  logic             take;
  logic             bad;
  logic             start;
  logic             last;
  logic [6:0]       instr;

  assign full      = load_count == 6'(DEPTH);
  assign busy      = state_q == EXEC;
  assign calc_mode = busy;
  assign calc_en   = busy | fwd_q;

  // ptr_b_q set means B is favoured on a tie
  assign open_c  = (state_q == LOAD) && !full
                && !run_start && !flush;
  assign grant_a = open_c && a_valid
                && (!b_valid || !ptr_b_q);
  assign grant_b = open_c && b_valid
                && (!a_valid || ptr_b_q);
  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign take    = grant_a | grant_b;
  assign instr   = grant_a ? a_instr : b_instr;
  assign bad     = instr[5:4] == 2'b11;

  assign start = (state_q == LOAD) && run_start
              && (run_len != '0);
  assign last  = busy && (cnt_q == RUN_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = LOAD;
    end else if (start) begin
      state_d = EXEC;
      cnt_d   = run_len;
    end else if (busy) begin
      cnt_d = cnt_q - RUN_W'(1);
      if (last) state_d = LOAD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_b_q     <= 1'b0;
      fwd_q       <= 1'b0;
      calc_opCode <= '0;
      calc_value  <= '0;
      calc_clr    <= 1'b0;
      rejected    <= 1'b0;
      done        <= 1'b0;
      load_count  <= '0;
    end else begin
      calc_clr <= flush;
      done     <= last && !flush;
      fwd_q    <= take && !bad;
      rejected <= take && bad;
      if (take) ptr_b_q <= grant_a;
      if (take && !bad) begin
        calc_opCode <= instr[6:4];
        calc_value  <= instr[3:0];
      end
      if (flush)
        load_count <= '0;
      else if (take && !bad)
        load_count <= load_count + 6'd1;
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: vector table,
// directed corner cases and a randomized reference model.
module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       a_valid, b_valid, a_ready, b_ready;
  logic [6:0] a_instr, b_instr;
  logic       run_start, flush;
  logic [7:0] run_len;
  logic       calc_mode, calc_en, calc_clr;
  logic [2:0] calc_opCode;
  logic [3:0] calc_value;
  logic [5:0] load_count;
  logic       full, busy, rejected, done;

  int n_chk = 0;
  int n_fail = 0;

  calc_sequencer dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_instr(a_instr), .a_ready(a_ready),
    .b_valid(b_valid), .b_instr(b_instr), .b_ready(b_ready),
    .run_start(run_start), .run_len(run_len), .flush(flush),
    .calc_mode(calc_mode), .calc_opCode(calc_opCode),
    .calc_value(calc_value), .calc_en(calc_en),
    .calc_clr(calc_clr), .load_count(load_count),
    .full(full), .busy(busy), .rejected(rejected), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic [6:0] ai;
    logic       bv;
    logic [6:0] bi;
    logic       rs;
    logic [7:0] rl;
    logic       fl;
    logic       ear;
    logic       ebr;
    logic       een;
    logic       emode;
    logic       erej;
    logic       edone;
    logic       eclr;
    logic [5:0] elc;
    logic       ebusy;
  } vec_t;

  vec_t vt[15];

  // model state for the random phase
  int         m_left, m_lc, m_run;
  bit         m_ptr_b, ga, gb, e_fwd, e_rej, e_done, ap, bp;
  logic [2:0] m_op;
  logic [3:0] m_val;
  logic [6:0] ainst, binst, acc;
  logic       rs_r, fl_r;
  logic [7:0] rl_r;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [6:0] ai,
                       input logic bv, input logic [6:0] bi,
                       input logic rs, input logic [7:0] rl,
                       input logic fl);
    a_valid = av; a_instr = ai;
    b_valid = bv; b_instr = bi;
    run_start = rs; run_len = rl; flush = fl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_en", calc_en, 0);
    chk("rst_mode", calc_mode, 0);
    chk("rst_op", calc_opCode, 0);
    chk("rst_val", calc_value, 0);
    chk("rst_clr", calc_clr, 0);
    chk("rst_lc", load_count, 0);
    chk("rst_full", full, 0);
    chk("rst_rej", rejected, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // av ai bv bi rs rl fl | ear ebr | en mode rej done clr lc busy
    vt[0]  = '{1'b1, 7'h11, 1'b1, 7'h42, 1'b0, 8'd0, 1'b0,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1, 1'b0};
    vt[1]  = '{1'b1, 7'h13, 1'b1, 7'h42, 1'b0, 8'd0, 1'b0,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd2, 1'b0};
    vt[2]  = '{1'b1, 7'h13, 1'b1, 7'h44, 1'b0, 8'd0, 1'b0,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd3, 1'b0};
    vt[3]  = '{1'b1, 7'h15, 1'b1, 7'h44, 1'b0, 8'd0, 1'b0,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd4, 1'b0};
    vt[4]  = '{1'b1, 7'h15, 1'b0, 7'h00, 1'b0, 8'd0, 1'b0,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd5, 1'b0};
    vt[5]  = '{1'b1, 7'h35, 1'b0, 7'h00, 1'b0, 8'd0, 1'b0,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd5, 1'b0};
    vt[6]  = '{1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 8'd0, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd5, 1'b0};
    vt[7]  = '{1'b1, 7'h07, 1'b0, 7'h00, 1'b1, 8'd3, 1'b0,
               1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd5, 1'b1};
    vt[8]  = '{1'b1, 7'h07, 1'b0, 7'h00, 1'b0, 8'd0, 1'b0,
               1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd5, 1'b1};
    vt[9]  = '{1'b1, 7'h07, 1'b0, 7'h00, 1'b1, 8'd2, 1'b0,
               1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd5, 1'b1};
    vt[10] = '{1'b1, 7'h07, 1'b0, 7'h00, 1'b0, 8'd0, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd5, 1'b0};
    vt[11] = '{1'b1, 7'h07, 1'b0, 7'h00, 1'b0, 8'd0, 1'b0,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd6, 1'b0};
    vt[12] = '{1'b0, 7'h00, 1'b0, 7'h00, 1'b1, 8'd0, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd6, 1'b0};
    vt[13] = '{1'b1, 7'h21, 1'b1, 7'h22, 1'b1, 8'd2, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0};
    vt[14] = '{1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 8'd0, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].av, vt[i].ai, vt[i].bv, vt[i].bi,
            vt[i].rs, vt[i].rl, vt[i].fl);
      #2;
      chk($sformatf("v%0d_a_ready", i), a_ready, vt[i].ear);
      chk($sformatf("v%0d_b_ready", i), b_ready, vt[i].ebr);
      tick();
      chk($sformatf("v%0d_en", i), calc_en, vt[i].een);
      chk($sformatf("v%0d_mode", i), calc_mode, vt[i].emode);
      chk($sformatf("v%0d_rej", i), rejected, vt[i].erej);
      chk($sformatf("v%0d_done", i), done, vt[i].edone);
      chk($sformatf("v%0d_clr", i), calc_clr, vt[i].eclr);
      chk($sformatf("v%0d_lc", i), load_count, vt[i].elc);
      chk($sformatf("v%0d_busy", i), busy, vt[i].ebusy);
    end

    // fill to capacity, then flush
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive(1, {3'b001, 4'(i)}, 0, 0, 0, 0, 0);
      #2;
      chk("fill_a_ready", a_ready, 1);
      tick();
    end
    chk("fill_lc", load_count, 32);
    chk("fill_full", full, 1);
    drive(1, 7'h1A, 0, 0, 0, 0, 0);
    #2;
    chk("full_a_ready", a_ready, 0);
    tick();
    chk("full_lc_hold", load_count, 32);
    drive(1, 7'h1A, 0, 0, 0, 0, 1);
    #2;
    chk("flush_a_ready", a_ready, 0);
    tick();
    chk("flush_clr", calc_clr, 1);
    chk("flush_lc", load_count, 0);
    chk("flush_full", full, 0);
    drive(1, 7'h1A, 0, 0, 0, 0, 0);
    #2;
    chk("after_flush_a_ready", a_ready, 1);
    tick();
    chk("after_flush_lc", load_count, 1);
    chk("after_flush_clr", calc_clr, 0);
    chk("after_flush_op", calc_opCode, 1);
    chk("after_flush_val", calc_value, 4'hA);

    // reset in the second cycle of a 4-cycle run
    drive(0, 0, 0, 0, 1, 8'd4, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("mid_exec_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_en", calc_en, 0);
    chk("arst_mode", calc_mode, 0);
    chk("arst_op", calc_opCode, 0);
    chk("arst_val", calc_value, 0);
    chk("arst_lc", load_count, 0);
    chk("arst_done", done, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end

    // randomized run against a reference model
    do_reset();
    m_left = 0; m_lc = 0; m_ptr_b = 0;
    m_op = 0; m_val = 0; ap = 0; bp = 0;
    ainst = 0; binst = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!ap && ($urandom % 3 != 0)) begin
        ap = 1; ainst = 7'($urandom);
      end
      if (!bp && ($urandom % 3 != 0)) begin
        bp = 1; binst = 7'($urandom);
      end
      rs_r = ($urandom % 8 == 0);
      rl_r = 8'($urandom % 6);
      fl_r = ($urandom % 60 == 0);
      drive(ap, ainst, bp, binst, rs_r, rl_r, fl_r);
      #2;
      ga = 0; gb = 0;
      if (m_left == 0 && m_lc != 32 && !rs_r && !fl_r) begin
        if (ap && bp) begin
          if (m_ptr_b) gb = 1;
          else ga = 1;
        end else if (ap) ga = 1;
        else if (bp) gb = 1;
      end
      chk("rnd_a_ready", a_ready, ga);
      chk("rnd_b_ready", b_ready, gb);
      e_fwd = 0; e_rej = 0; e_done = 0;
      if (fl_r) begin
        m_lc = 0;
        m_left = 0;
      end else if (m_left == 0) begin
        if (rs_r && rl_r != 0) begin
          m_left = rl_r;
        end else if (ga || gb) begin
          acc = ga ? ainst : binst;
          m_ptr_b = ga;
          if (acc[6:4] == 3'd3 || acc[6:4] == 3'd7) begin
            e_rej = 1;
          end else begin
            e_fwd = 1;
            m_op = acc[6:4];
            m_val = acc[3:0];
            m_lc++;
          end
          if (ga) ap = 0;
          else bp = 0;
        end
      end else begin
        m_left--;
        e_done = (m_left == 0);
      end
      m_run = (m_left != 0) ? 1 : 0;
      tick();
      chk("rnd_busy", busy, m_run);
      chk("rnd_mode", calc_mode, m_run);
      chk("rnd_en", calc_en, (m_run != 0) || e_fwd);
      chk("rnd_clr", calc_clr, fl_r);
      chk("rnd_rej", rejected, e_rej);
      chk("rnd_done", done, e_done);
      chk("rnd_lc", load_count, m_lc);
      chk("rnd_full", full, m_lc == 32);
      chk("rnd_op", calc_opCode, m_op);
      chk("rnd_val", calc_value, m_val);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
